tri_solver: RTL and testbench

//  Parametrised triangular-system solver: computes x from T*x = Y with T unit-diagonal, upper or lower.

---
 rtl/tri_solver_pkg.sv | 35 +++
 rtl/tri_solver_mac.sv | 30 +++
 rtl/tri_solver.sv | 198 +++++++++++++++++++
 tb/tb_tri_solver.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_solver_pkg.sv
// Shared definitions for the triangular solver: memory opcodes, FSM state encoding
// and the triangle-orientation constants.
package tri_solver_defs;

    localparam logic [2:0] OP_GET_N   = 3'b000;
    localparam logic [2:0] OP_READ_Y  = 3'b001;
    localparam logic [2:0] OP_READ_A  = 3'b010;
    localparam logic [2:0] OP_READ_X  = 3'b011;
    localparam logic [2:0] OP_WRITE_X = 3'b100;
    localparam logic [2:0] OP_IDLE    = 3'b111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GET_N   = 3'd1;
    localparam logic [2:0] ST_READ_Y  = 3'd2;
    localparam logic [2:0] ST_READ_A  = 3'd3;
    localparam logic [2:0] ST_READ_X  = 3'd4;
    localparam logic [2:0] ST_WRITE_X = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic MODE_UPPER = 1'b0;
    localparam logic MODE_LOWER = 1'b1;

    // Memory opcode presented while sitting in a given state.
    function automatic logic [2:0] state_opcode(input logic [2:0] st);
        case (st)
            ST_GET_N:   return OP_GET_N;
            ST_READ_Y:  return OP_READ_Y;
            ST_READ_A:  return OP_READ_A;
            ST_READ_X:  return OP_READ_X;
            ST_WRITE_X: return OP_WRITE_X;
            default:    return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tri_solver_mac.sv
// Truncating multiply-accumulate: acc <= acc + a*b modulo 2^DW, with synchronous clear.
module tri_solver_mac #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] acc_o
);

    logic [DW-1:0] acc_q;

    // Only the low DW bits of the product can reach the accumulator, so the
    // multiply is kept DW wide; the result equals the truncated 2*DW product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + (a_i * b_i);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tri_solver.sv
// Unit-diagonal triangular solver (back or forward substitution) driving a shared
// matrix/vector memory through an opcode/i/j request port with ack handshake.
module tri_solver
    import tri_solver_defs::*;
#(
    parameter int DW    = 20,
    parameter int IW    = 20,
    parameter int MAX_N = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          mem_ack,
    input  logic [DW-1:0] in_data,
    output logic          req_valid,
    output logic [2:0]    opcode,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [IW-1:0] ONE = IW'(1);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] n_q, n_d;
    logic [IW-1:0] r_q, r_d;
    logic [IW-1:0] c_q, c_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] a_q, a_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;

    logic [IW-1:0] n_last;
    logic [DW-1:0] acc;
    logic          mac_clear;
    logic          mac_en;
    logic          upper;

    assign n_last    = n_q - ONE;
    assign upper     = (mode_q == MODE_UPPER);
    assign mac_clear = (state_q == ST_READ_Y) && mem_ack;
    assign mac_en    = (state_q == ST_READ_X) && mem_ack;

    tri_solver_mac #(.DW(DW)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .a_i     (a_q),
        .b_i     (in_data),
        .acc_o   (acc)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        c_d     = c_q;
        y_d     = y_q;
        a_d     = a_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GET_N;
                    mode_d  = mode;
                    err_d   = 1'b0;
                end
            end
            ST_GET_N: begin
                if (mem_ack) begin
                    if (in_data == '0) begin
                        state_d = ST_DONE;
                    end else if (in_data > DW'(MAX_N)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d     = IW'(in_data);
                        r_d     = upper ? (IW'(in_data) - ONE) : '0;
                        state_d = ST_READ_Y;
                    end
                end
            end
            ST_READ_Y: begin
                if (mem_ack) begin
                    y_d = in_data;
                    if (upper) begin
                        c_d     = r_q + ONE;
                        state_d = (r_q == n_last) ? ST_WRITE_X : ST_READ_A;
                    end else begin
                        c_d     = '0;
                        state_d = (r_q == '0) ? ST_WRITE_X : ST_READ_A;
                    end
                end
            end
            ST_READ_A: begin
                if (mem_ack) begin
                    a_d     = in_data;
                    state_d = ST_READ_X;
                end
            end
            ST_READ_X: begin
                if (mem_ack) begin
                    // Upper rows sweep columns up to n-1, lower rows up to r-1.
                    if ((upper && c_q == n_last) || (!upper && c_q == r_q - ONE)) begin
                        state_d = ST_WRITE_X;
                    end else begin
                        c_d     = c_q + ONE;
                        state_d = ST_READ_A;
                    end
                end
            end
            ST_WRITE_X: begin
                if (mem_ack) begin
                    if ((upper && r_q == '0) || (!upper && r_q == n_last)) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = upper ? (r_q - ONE) : (r_q + ONE);
                        state_d = ST_READ_Y;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            mode_q  <= MODE_UPPER;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            r_q     <= r_d;
            c_q     <= c_d;
            y_q     <= y_d;
            a_q     <= a_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        req_valid = 1'b0;
        i         = '0;
        j         = '0;
        out_data  = '0;
        case (state_q)
            ST_GET_N: begin
                req_valid = 1'b1;
            end
            ST_READ_Y: begin
                req_valid = 1'b1;
                i         = r_q;
            end
            ST_READ_A: begin
                req_valid = 1'b1;
                i         = r_q;
                j         = c_q;
            end
            ST_READ_X: begin
                req_valid = 1'b1;
                i         = c_q;
            end
            ST_WRITE_X: begin
                req_valid = 1'b1;
                i         = r_q;
                out_data  = y_q - acc;
            end
            default: begin
                req_valid = 1'b0;
            end
        endcase
    end

    assign opcode = state_opcode(state_q);
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_tri_solver.sv
// Self-checking bench for tri_solver: a memory responder serves requests while a
// scoreboard of expected (index, x) writes is popped as write_x requests are acked.
module tb_tri_solver;

    localparam int DW    = 20;
    localparam int IW    = 20;
    localparam int MAX_N = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          req_valid;
    logic [2:0]    opcode;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_n;
    logic [DW-1:0] mem_y [4];
    logic [DW-1:0] mem_a [4][4];
    logic [DW-1:0] mem_x [4];

    int            exp_idx_q [$];
    logic [DW-1:0] exp_val_q [$];

    tri_solver #(.DW(DW), .IW(IW), .MAX_N(MAX_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .mem_ack   (mem_ack),
        .in_data   (in_data),
        .req_valid (req_valid),
        .opcode    (opcode),
        .i         (i),
        .j         (j),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int r = 0; r < 4; r++) begin
            mem_y[r] = '0;
            mem_x[r] = '0;
            for (int c = 0; c < 4; c++) mem_a[r][c] = '0;
        end
    endtask

    task automatic load_case1();
        clear_mem();
        mem_n = 3;
        mem_y[0] = 20; mem_y[1] = 11; mem_y[2] = 3;
        mem_a[0][1] = 2; mem_a[0][2] = 3; mem_a[1][2] = 4;
    endtask

    task automatic load_case2();
        clear_mem();
        mem_n = 3;
        mem_y[0] = 5; mem_y[1] = 12; mem_y[2] = 20;
        mem_a[1][0] = 2; mem_a[2][0] = 1; mem_a[2][1] = 3;
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] val);
        exp_idx_q.push_back(idx);
        exp_val_q.push_back(val);
    endtask

    task automatic launch(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
    endtask

    // Serves memory until done (or budget/abort). Cycle 1 is the cycle after start is accepted.
    task automatic serve(input int budget, input int stall_len, input int restart_at,
                         input bit abort_readx, output int cycles, output int nreq,
                         output int nwrites);
        bit stalling = 0;
        bit stall_used = 0;
        int stall_left = 0;
        logic [2:0] s_op = '0;
        logic [IW-1:0] s_i = '0;
        logic [IW-1:0] s_j = '0;
        bit finished = 0;
        int idx;
        cycles = 0; nreq = 0; nwrites = 0;
        while (!finished && cycles < budget) begin
            @(negedge clk);
            cycles++;
            start   = (cycles == restart_at);
            mem_ack = 1'b0;
            in_data = '0;
            if (done) begin
                finished = 1;
            end else if (req_valid) begin
                nreq++;
                idx = int'(i) & 3;
                if (abort_readx && opcode == 3'b011) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({req_valid, opcode, i, j, out_data, busy, done, err} !==
                        {1'b0, 3'b111, {IW{1'b0}}, {IW{1'b0}}, {DW{1'b0}}, 3'b000}) begin
                        errors++;
                        $display("FAIL abort_reset: req_valid=%0b opcode=%0b i=%0d j=%0d out_data=%0h busy=%0b done=%0b err=%0b, required reset values",
                                 req_valid, opcode, i, j, out_data, busy, done, err);
                    end
                    finished = 1;
                end else begin
                    mem_ack = 1'b1;
                    if (opcode == 3'b010 && stall_len > 0 && !stall_used) begin
                        if (!stalling) begin
                            stalling = 1; stall_left = stall_len;
                            s_op = opcode; s_i = i; s_j = j;
                        end else begin
                            checks++;
                            if ({opcode, i, j} !== {s_op, s_i, s_j}) begin
                                errors++;
                                $display("FAIL stall_stable: opcode=%0b i=%0d j=%0d, required opcode=%0b i=%0d j=%0d",
                                         opcode, i, j, s_op, s_i, s_j);
                            end
                        end
                        if (stall_left > 0) begin
                            stall_left--;
                            mem_ack = 1'b0;
                        end else begin
                            stall_used = 1;
                        end
                    end
                    if (mem_ack) begin
                        case (opcode)
                            3'b000: in_data = mem_n;
                            3'b001: in_data = mem_y[idx];
                            3'b010: in_data = mem_a[idx][int'(j) & 3];
                            3'b011: in_data = mem_x[idx];
                            3'b100: begin
                                mem_x[idx] = out_data;
                                nwrites++;
                                checks++;
                                if (exp_idx_q.size() == 0) begin
                                    errors++;
                                    $display("FAIL write_x: unexpected write i=%0d data=%0h, required no write", i, out_data);
                                end else begin
                                    int e_i;
                                    logic [DW-1:0] e_v;
                                    e_i = exp_idx_q.pop_front();
                                    e_v = exp_val_q.pop_front();
                                    if (int'(i) !== e_i || out_data !== e_v) begin
                                        errors++;
                                        $display("FAIL write_x: got i=%0d data=%0h, required i=%0d data=%0h", i, out_data, e_i, e_v);
                                    end else begin
                                        $display("write_x i=%0d data=%0h", i, out_data);
                                    end
                                end
                            end
                            default: in_data = '0;
                        endcase
                    end
                end
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles, required done", budget);
        end
    endtask

    task automatic check_run(input string name, input int cycles, input int exp_cycles,
                             input int nwrites, input int exp_writes, input logic exp_err);
        checks++;
        if (cycles !== exp_cycles || nwrites !== exp_writes || err !== exp_err || busy !== 1'b0
            || exp_idx_q.size() != 0) begin
            errors++;
            $display("FAIL %s: cycles=%0d writes=%0d err=%0b busy=%0b pending=%0d, required cycles=%0d writes=%0d err=%0b busy=0 pending=0",
                     name, cycles, nwrites, err, busy, exp_idx_q.size(), exp_cycles, exp_writes, exp_err);
        end else begin
            $display("run %s: done after %0d cycles, %0d writes", name, cycles, nwrites);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_valid, opcode, i, j, out_data, busy, done, err} !==
            {1'b0, 3'b111, {IW{1'b0}}, {IW{1'b0}}, {DW{1'b0}}, 3'b000}) begin
            errors++;
            $display("FAIL reset: req_valid=%0b opcode=%0b i=%0d busy=%0b done=%0b err=%0b, required idle reset values",
                     req_valid, opcode, i, busy, done, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_upper();
        int cyc, nreq, nw;
        load_case1();
        push_exp(2, 20'd3); push_exp(1, 20'hFFFFF); push_exp(0, 20'd13);
        launch(1'b0);
        serve(200, 0, 0, 0, cyc, nreq, nw);
        check_run("upper", cyc, 14, nw, 3, 1'b0);
    endtask

    task automatic test_lower();
        int cyc, nreq, nw;
        load_case2();
        push_exp(0, 20'd5); push_exp(1, 20'd2); push_exp(2, 20'd9);
        launch(1'b1);
        serve(200, 0, 0, 0, cyc, nreq, nw);
        check_run("lower", cyc, 14, nw, 3, 1'b0);
    endtask

    task automatic test_stall();
        int cyc, nreq, nw;
        load_case1();
        push_exp(2, 20'd3); push_exp(1, 20'hFFFFF); push_exp(0, 20'd13);
        launch(1'b0);
        serve(200, 3, 0, 0, cyc, nreq, nw);
        check_run("stall", cyc, 17, nw, 3, 1'b0);
    endtask

    task automatic test_range();
        int cyc, nreq, nw;
        clear_mem();
        mem_n = 0;
        launch(1'b0);
        serve(50, 0, 0, 0, cyc, nreq, nw);
        check_run("n_zero", cyc, 2, nw, 0, 1'b0);
        mem_n = DW'(MAX_N + 1);
        launch(1'b1);
        serve(50, 0, 0, 0, cyc, nreq, nw);
        check_run("n_over", cyc, 2, nw, 0, 1'b1);
        checks++;
        if (nreq !== 1) begin
            errors++;
            $display("FAIL n_over_requests: requests=%0d, required 1", nreq);
        end
        for (int k = 0; k < 3; k++) @(negedge clk);
        checks++;
        if (err !== 1'b1 || req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_hold: err=%0b req_valid=%0b busy=%0b, required err=1 req_valid=0 busy=0", err, req_valid, busy);
        end
        load_case1();
        push_exp(2, 20'd3); push_exp(1, 20'hFFFFF); push_exp(0, 20'd13);
        launch(1'b0);
        serve(200, 0, 0, 0, cyc, nreq, nw);
        check_run("err_clear", cyc, 14, nw, 3, 1'b0);
    endtask

    task automatic test_abort();
        int cyc, nreq, nw;
        load_case2();
        push_exp(0, 20'd5); push_exp(1, 20'd2); push_exp(2, 20'd9);
        launch(1'b1);
        serve(200, 0, 0, 1, cyc, nreq, nw);
        exp_idx_q.delete();
        exp_val_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: req_valid=%0b busy=%0b, required 0 0", req_valid, busy);
            end
        end
        rst_n = 1'b1;
        load_case2();
        push_exp(0, 20'd5); push_exp(1, 20'd2); push_exp(2, 20'd9);
        launch(1'b1);
        serve(200, 0, 0, 0, cyc, nreq, nw);
        check_run("after_abort", cyc, 14, nw, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc, nreq, nw;
        clear_mem();
        mem_n = 1;
        mem_y[0] = 20'h7ABCD;
        push_exp(0, 20'h7ABCD);
        launch(1'b0);
        serve(50, 0, 3, 0, cyc, nreq, nw);
        check_run("n1_upper_restart", cyc, 4, nw, 1, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored: busy=%0b req_valid=%0b, required 0 0", busy, req_valid);
        end
        mem_y[0] = 20'd42;
        push_exp(0, 20'd42);
        launch(1'b1);
        serve(50, 0, 2, 0, cyc, nreq, nw);
        check_run("n1_lower_restart", cyc, 4, nw, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_upper();
        test_lower();
        test_stall();
        test_range();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
